// File: rtl/asm_line_decoder.sv
// asm_line_decoder: parses ASCII noop/addx lines (in_* byte stream) into per-cycle {op,arg} records (out_*), with sticky err and word_count
module asm_line_decoder #(
  parameter int ARG_W = 16,
  parameter int MAX_DIGITS = 5
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ARG_W:0]   out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err,
  output logic [31:0]      word_count
);
  localparam int CW = $clog2(MAX_DIGITS + 2);
  localparam logic [32:0] NEG_LIM = 33'd1 << (ARG_W - 1);
  localparam logic [32:0] POS_LIM = NEG_LIM - 33'd1;
  typedef enum logic [3:0] {IDLE, NOOP_M, ADDX_M, SPACE, SIGN, DIGITS, EOL_N, EMIT0, EMIT1, SKIP} state_e;
  state_e state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic neg_q, neg_d, addx_q, addx_d, err_q, err_d, ov_q, ov_d;
  logic [17:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ARG_W:0] od_q, od_d;
  logic [31:0] wc_q;
  logic take, hs, is_dig, is_nl, is_cr, bad, over;
  logic [ARG_W-1:0] mag, arg;
  assign in_ready = RST_N & (state_q != EMIT0) & (state_q != EMIT1);
  assign take = in_valid & in_ready;
  assign hs = ov_q & out_ready;
  assign is_dig = (in_data >= 8'h30) && (in_data <= 8'h39);
  assign is_nl = in_data == 8'h0a;
  assign is_cr = in_data == 8'h0d;
  assign over = (cnt_q > CW'(MAX_DIGITS)) || ({15'd0, acc_q} > (neg_q ? NEG_LIM : POS_LIM));
  assign mag = ARG_W'(acc_q);
  assign arg = neg_q ? -mag : mag;
  assign out_data = od_q;
  assign out_valid = ov_q;
  assign err = err_q;
  assign word_count = wc_q;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    neg_d = neg_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    addx_d = addx_q;
    err_d = err_q;
    ov_d = ov_q;
    od_d = od_q;
    bad = 1'b0;
    case (state_q)
      IDLE: if (take) begin
        idx_d = 2'd0;
        if (in_data == 8'h6e) begin
          state_d = NOOP_M;
          addx_d = 1'b0;
        end else if (in_data == 8'h61) begin
          state_d = ADDX_M;
          addx_d = 1'b1;
          acc_d = '0;
          neg_d = 1'b0;
          cnt_d = '0;
        end else if (!is_nl && !is_cr) begin
          state_d = SKIP;
          err_d = 1'b1;
        end
      end
      NOOP_M: if (take) begin
        if (in_data == ((idx_q == 2'd2) ? 8'h70 : 8'h6f)) begin
          idx_d = idx_q + 2'd1;
          state_d = (idx_q == 2'd2) ? EOL_N : NOOP_M;
        end else bad = 1'b1;
      end
      ADDX_M: if (take) begin
        if (in_data == ((idx_q == 2'd2) ? 8'h78 : 8'h64)) begin
          idx_d = idx_q + 2'd1;
          state_d = (idx_q == 2'd2) ? SPACE : ADDX_M;
        end else bad = 1'b1;
      end
      SPACE: if (take) begin
        if (in_data == 8'h20) state_d = SIGN;
        else bad = 1'b1;
      end
      SIGN: if (take) begin
        if (in_data == 8'h2d) begin
          neg_d = 1'b1;
          state_d = DIGITS;
        end else if (is_dig) begin
          acc_d = {14'd0, in_data[3:0]};
          cnt_d = CW'(1);
          state_d = DIGITS;
        end else bad = 1'b1;
      end
      DIGITS: if (take) begin
        if (is_dig) begin
          acc_d = acc_q * 18'd10 + {14'd0, in_data[3:0]};
          cnt_d = (cnt_q > CW'(MAX_DIGITS)) ? cnt_q : cnt_q + CW'(1);
        end else if (is_nl && cnt_q != '0) begin
          state_d = over ? IDLE : EMIT0;
          err_d = err_q | over;
          ov_d = !over;
          od_d = '0;
        end else if (!is_cr) bad = 1'b1;
      end
      EOL_N: if (take) begin
        if (is_nl) begin
          state_d = EMIT0;
          ov_d = 1'b1;
          od_d = '0;
        end else if (!is_cr) bad = 1'b1;
      end
      EMIT0: if (hs) begin
        state_d = addx_q ? EMIT1 : IDLE;
        ov_d = addx_q;
        od_d = addx_q ? {1'b1, arg} : od_q;
      end
      EMIT1: if (hs) begin
        state_d = IDLE;
        ov_d = 1'b0;
      end
      SKIP: if (take && is_nl) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bad) begin
      err_d = 1'b1;
      state_d = is_nl ? IDLE : SKIP;
    end
  end
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      idx_q <= '0;
      neg_q <= 1'b0;
      acc_q <= '0;
      cnt_q <= '0;
      addx_q <= 1'b0;
      err_q <= 1'b0;
      ov_q <= 1'b0;
      od_q <= '0;
      wc_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      neg_q <= neg_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      addx_q <= addx_d;
      err_q <= err_d;
      ov_q <= ov_d;
      od_q <= od_d;
      wc_q <= wc_q + 32'(hs);
    end
  end
endmodule

// File: doc/asm_line_decoder.md
# asm_line_decoder

Upstream stage of the day-10 CPU datapath: accepts the puzzle program as a raw ASCII byte stream (`noop` / `addx <signed int>` lines) and emits one 17-bit per-cycle record per CPU clock cycle. Each record is `{op, arg[15:0]}`, the same format the CPU stage consumes from its program ROM. `addx` is expanded into its two-cycle form, so the consumer advances exactly one record per CPU cycle. The block replaces the offline ROM pre-expansion step and lets the program be streamed in, for example from a UART receiver.

## Interface

Parameters:
- `ARG_W`, default 16: width of the arg field. The record is `ARG_W+1` bits.
- `MAX_DIGITS`, default 5: maximum number of decimal digits accepted in an `addx` operand.

Ports:
- `CLK`, input, 1: system clock (16 MHz). The block has one clock; reset is synchronous and active-low.
- `RST_N`, input, 1: synchronous active-low reset, sampled on `posedge CLK`.
- `in_data`, input, 8: ASCII byte.
- `in_valid`, input, 1: `in_data` is valid.
- `in_ready`, output, 1: the block accepts a byte this cycle.
- `out_data`, output, `ARG_W+1`: `{op, arg}` record. `op` is the MSB.
- `out_valid`, output, 1: `out_data` is valid.
- `out_ready`, input, 1: the consumer accepts the record this cycle.
- `err`, output, 1: sticky parse-error flag.
- `word_count`, output, 32: number of records accepted by the consumer.

## Operation

- Byte handshake: a byte transfers when `in_valid && in_ready`. Record handshake: a record transfers when `out_valid && out_ready`.
- State machine:
  - `IDLE`
    - `n` → `NOOP_M`
    - `a` → `ADDX_M`
    - `\n` or `\r`: ignored (blank line)
    - any other byte → `SKIP`, and `err` is set
  - `NOOP_M`: must receive `o`, `o`, `p` in order (internal index 0..2), then → `EOL_N`.
  - `ADDX_M`: must receive `d`, `d`, `x`, then → `SPACE`.
  - `SPACE`: must receive `' '`, then → `SIGN`.
  - `SIGN`
    - `-`: sets `neg`, → `DIGITS`
    - digit: loads accumulator, → `DIGITS`
    - anything else: error
  - `DIGITS`
    - digit: `acc <= acc*10 + d`; digit count +1
    - `\r`: ignored
    - `\n` with at least 1 digit → `EMIT0`
  - `EOL_N`: `\r` is ignored; `\n` → `EMIT0`.
  - `EMIT0`: presents `{1'b0, 0}`. On handshake: → `EMIT1` if the line was `addx`, otherwise → `IDLE`.
  - `EMIT1`: presents `{1'b1, arg}`. On handshake → `IDLE`.
  - `SKIP`: discards bytes until `\n`, then → `IDLE`. No records are emitted for the bad line.
- Any unexpected byte in the parse states (`NOOP_M` through `EOL_N`):
  - sets `err`;
  - if the byte is `\n`, the next state is `IDLE`; otherwise → `SKIP`.
- Operand arithmetic:
  - `acc` is 18 bits unsigned.
  - Range check at `\n`: magnitude ≤ 2^(ARG_W-1)−1 when positive, ≤ 2^(ARG_W-1) when negative.
  - More than `MAX_DIGITS` digits, or out of range: error, line dropped.
  - `arg = neg ? -acc : acc`, truncated to `ARG_W`, two's complement.
  - `-0` encodes as 0.
- `err` stays set until reset; parsing continues after resync.
- `word_count` increments by 1 on every record handshake and wraps modulo 2^32.

## Timing

- Reset (`RST_N` low at a clock edge) gives, on the next cycle:
  - state `IDLE`, `out_valid=0`, `out_data=0`, `err=0`, `word_count=0`;
  - accumulator, `neg` and digit count cleared.
- `in_ready` is 0 while `RST_N` is low.
- `in_ready` is 1 in `IDLE`, `NOOP_M` through `EOL_N`, and `SKIP`. It is 0 in `EMIT0` and `EMIT1`.
- Throughput: one byte per cycle while parsing.
- Latency: `out_valid` rises in the cycle after the `\n` byte handshake.
- Emission rules:
  - `out_data` and `out_valid` are registered and held stable while `out_valid && !out_ready`.
  - Back-to-back records: `EMIT0` → `EMIT1` with no bubble when `out_ready=1`.
  - After the last record handshake, `in_ready=1` in the next cycle.
- Minimum cycles per line:
  - `noop`: 5 bytes + 1 record = 6 cycles.
  - `addx N`: byte count + 2 cycles.
- Reset asserted mid-line or mid-emission: the partial line and any pending record are discarded. The consumer never sees a half-expanded `addx`, because `out_valid` drops at the reset edge.
- Bytes presented while `in_ready=0` are not consumed. The source holds them.

## Test plan

- `noop\n` with `out_ready=1` → exactly one record, `0x00000`, one cycle after the `\n` handshake; `word_count=1`; `err=0`.
- `addx 3\naddx -5\n` → records `0x00000`, `0x10003`, `0x00000`, `0x1FFFB` in order; `word_count=4`.
- `addx 7\r\n` with `out_ready` low for 3 cycles after `out_valid` rises → `0x00000` is held stable for 4 cycles, then `0x10007` follows; `in_ready=0` throughout emission.
- `addy 1\nnoop\n` → `err=1` after the 4th byte; only `0x00000` is emitted (from the `noop`); `err` remains 1.
- Range limits:
  - `addx 32767\n` → second record `0x17FFF`.
  - `addx -32768\n` → second record `0x18000`.
  - `addx 32768\n` and `addx 123456\n` → no records, `err=1`.
- `RST_N` pulsed low while `EMIT1` is pending for `addx 9\n` → `out_valid=0` and `word_count=0` next cycle; a following `noop\n` yields a single `0x00000`.
